// File: rtl/clb_cluster_if.sv
// Configuration-chain and user-logic signals of one CLB cluster.
interface clb_cluster_if #(
    parameter int K = 4,
    parameter int N = 2
);
    logic           prog_en;
    logic           prog_in;
    logic           prog_out;
    logic [N*K-1:0] clb_in;
    logic [N-1:0]   clb_out;
    logic           cfg_done;
    logic           cfg_err;

    modport master (
        output prog_en, prog_in, clb_in,
        input  prog_out, clb_out, cfg_done, cfg_err
    );

    modport slave (
        input  prog_en, prog_in, clb_in,
        output prog_out, clb_out, cfg_done, cfg_err
    );
endinterface

// File: rtl/clb_cluster.sv
// CLB cluster: N K-input BLEs loaded through a serial shadow chain with atomic commit.
// Optional CLB_CFG_PARITY_EN appends an even-parity bit to the chain.
module clb_ble #(
    parameter int K = 4
) (
    input  logic              clb_clk,
    input  logic              rst,
    input  logic              run_en_i,
    input  logic [2**K-1:0]   lut_tt_i,
    input  logic              sel_i,
    input  logic              init_i,
    input  logic [K-1:0]      lut_in_i,
    output logic              out_o
);
    logic lut_out;
    logic ff_q, ff_d;

    assign lut_out = lut_tt_i[lut_in_i];
    // Hold the init value until the committed config has crossed into clb_clk.
    assign ff_d    = run_en_i ? lut_out : init_i;

    always_ff @(posedge clb_clk or negedge rst) begin
        if (!rst) ff_q <= 1'b0;
        else      ff_q <= ff_d;
    end

    assign out_o = sel_i ? ff_q : lut_out;
endmodule

module clb_cluster #(
    parameter int K = 4,
    parameter int N = 2
) (
    input  logic          prog_clk,
    input  logic          rst,
    input  logic          clb_clk,
    clb_cluster_if.slave  bus
);
    localparam int LUT_W = 2**K;
    localparam int B     = LUT_W + 2;
    localparam int CFG_W = N * B;
`ifdef CLB_CFG_PARITY_EN
    localparam int CHAIN_W = CFG_W + 1;
`else
    localparam int CHAIN_W = CFG_W;
`endif
    localparam int CNT_W = $clog2(CHAIN_W + 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ACTIVE} state_t;

    state_t             state_q, state_d;
    logic [CHAIN_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0]   cfg_q, cfg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               par_ok;
    logic [1:0]         sync_q;
    logic               run_en;
    logic [N-1:0]       clb_out;

`ifdef CLB_CFG_PARITY_EN
    assign par_ok = ~(^shadow_q);
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge prog_clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            cfg_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cfg_q    <= cfg_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cfg_d    = cfg_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        err_d    = err_q;
        if (bus.prog_en) shadow_d = {bus.prog_in, shadow_q[CHAIN_W-1:1]};
        case (state_q)
            IDLE, ACTIVE: begin
                if (bus.prog_en) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_ONE;
                    err_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (bus.prog_en) begin
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_ONE;
                end else if (cnt_q == CNT_FULL && par_ok) begin
                    cfg_d   = shadow_q[CFG_W-1:0];
                    done_d  = 1'b1;
                    state_d = ACTIVE;
                end else begin
                    // Bad load: keep whatever config was running before.
                    err_d   = 1'b1;
                    state_d = done_q ? ACTIVE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clb_clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[0], done_q};
    end
    assign run_en = sync_q[1];

    for (genvar i = 0; i < N; i++) begin : g_ble
        clb_ble #(.K(K)) u_ble (
            .clb_clk  (clb_clk),
            .rst      (rst),
            .run_en_i (run_en),
            .lut_tt_i (cfg_q[i*B +: LUT_W]),
            .sel_i    (cfg_q[i*B + LUT_W]),
            .init_i   (cfg_q[i*B + LUT_W + 1]),
            .lut_in_i (bus.clb_in[i*K +: K]),
            .out_o    (clb_out[i])
        );
    end

    assign bus.clb_out  = clb_out;
    assign bus.prog_out = shadow_q[0];
    assign bus.cfg_done = done_q;
    assign bus.cfg_err  = err_q;
endmodule

// File: tb/tb_clb_cluster.sv
// Directed bench for clb_cluster (K=4, N=2): load, commit, abort, reload and reset cases.
module tb_clb_cluster;
    localparam int K     = 4;
    localparam int N     = 2;
    localparam int CFG_W = 36;
`ifdef CLB_CFG_PARITY_EN
    localparam int CW = CFG_W + 1;
`else
    localparam int CW = CFG_W;
`endif

    logic prog_clk = 1'b0;
    logic clb_clk  = 1'b0;
    logic rst      = 1'b0;

    clb_cluster_if #(.K(K), .N(N)) bus ();

    clb_cluster #(.K(K), .N(N)) dut (
        .prog_clk (prog_clk),
        .rst      (rst),
        .clb_clk  (clb_clk),
        .bus      (bus)
    );

    // prog_clk rises on odd ns, clb_clk on even ns: the two never share an edge.
    always #5 prog_clk = ~prog_clk;
    always #8 clb_clk  = ~clb_clk;

    typedef struct {
        logic [7:0] in;
        logic [1:0] exp;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #2;
    endtask

    task automatic clb_wait(input int n);
        repeat (n) @(posedge clb_clk);
        #2;
    endtask

    task automatic shift_in(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus.prog_in = v[i];
            bus.prog_en = 1'b1;
            tick();
        end
        bus.prog_en = 1'b0;
    endtask

    function automatic logic [63:0] frame(input logic [35:0] cfg, input logic bad_par);
`ifdef CLB_CFG_PARITY_EN
        return {27'b0, (^cfg) ^ bad_par, cfg};
`else
        return {28'b0, cfg};
`endif
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        logic [35:0] cfg_a;
        logic [63:0] pat;

        // BLE0: 4-input AND, combinational. BLE1: 4-input XOR, registered, init 0.
        cfg_a = {1'b0, 1'b1, 16'h6996, 1'b0, 1'b0, 16'h8000};
        pat   = 64'h0000_00A5_3C96_0FE1;
        vecs[0] = '{8'h1F, 2'b11};
        vecs[1] = '{8'h00, 2'b00};
        vecs[2] = '{8'h3E, 2'b00};
        vecs[3] = '{8'h7F, 2'b11};
        vecs[4] = '{8'hFF, 2'b01};
        vecs[5] = '{8'h8E, 2'b10};

        bus.prog_en = 1'b0;
        bus.prog_in = 1'b0;
        bus.clb_in  = 8'h1F;
        #3;
        chk("rst_done",  bus.cfg_done, 1'b0);
        chk("rst_err",   bus.cfg_err,  1'b0);
        chk("rst_pout",  bus.prog_out, 1'b0);
        chk("rst_out",   bus.clb_out,  2'b00);
        tick();
        rst = 1'b1;
        tick();

        // Full load, then watch the registered BLE wait for run_en.
        shift_in(frame(cfg_a, 1'b0), CW);
        chk("pre_commit_done", bus.cfg_done, 1'b0);
        @(posedge prog_clk);
        fork
            begin
                #2;
                chk("commit_done", bus.cfg_done, 1'b1);
                chk("commit_err",  bus.cfg_err,  1'b0);
                chk("commit_out0", bus.clb_out[0], 1'b1);
                chk("commit_out1", bus.clb_out[1], 1'b0);
            end
            begin
                repeat (2) @(posedge clb_clk);
                #2;
                chk("sync_out1_lo", bus.clb_out[1], 1'b0);
                @(posedge clb_clk);
                #2;
                chk("sync_out1_hi", bus.clb_out[1], 1'b1);
            end
        join

        for (int i = 0; i < 6; i++) begin
            bus.clb_in = vecs[i].in;
            clb_wait(3);
            chk($sformatf("vec%0d_out", i), bus.clb_out, vecs[i].exp);
        end

        // Short load from a clean state.
        bus.clb_in = 8'h1F;
        tick();
        rst = 1'b0;
        tick();
        chk("rst2_done", bus.cfg_done, 1'b0);
        rst = 1'b1;
        shift_in(frame(cfg_a, 1'b0), CW - 1);
        tick();
        chk("short_err",  bus.cfg_err,  1'b1);
        chk("short_done", bus.cfg_done, 1'b0);
        chk("short_out",  bus.clb_out,  2'b00);

        // Over-long load: chain acts as a CW-deep delay line, then aborts.
        for (int j = 0; j < 40; j++) begin
            bus.prog_in = pat[j];
            bus.prog_en = 1'b1;
            tick();
            if (j == 0) chk("long_err_clr", bus.cfg_err, 1'b0);
            if (j >= CW - 1) chk($sformatf("delay_%0d", j), bus.prog_out, pat[j-CW+1]);
        end
        bus.prog_en = 1'b0;
        tick();
        chk("long_err",  bus.cfg_err,  1'b1);
        chk("long_done", bus.cfg_done, 1'b0);

        // Reset in the middle of a load.
        shift_in(frame(cfg_a, 1'b0), 20);
        rst = 1'b0;
        #1;
        chk("midrst_done", bus.cfg_done, 1'b0);
        chk("midrst_err",  bus.cfg_err,  1'b0);
        chk("midrst_out",  bus.clb_out,  2'b00);
        chk("midrst_pout", bus.prog_out, 1'b0);
        tick();
        rst = 1'b1;
        shift_in(frame(cfg_a, 1'b0), CW);
        tick();
        chk("reload_done", bus.cfg_done, 1'b1);
        chk("reload_err",  bus.cfg_err,  1'b0);

        // Reload while active: old function holds until the commit edge.
        clb_wait(3);
        chk("active_out", bus.clb_out, 2'b11);
        for (int j = 0; j < CW; j++) begin
            bus.prog_in = 1'b0;
            bus.prog_en = 1'b1;
            tick();
            chk($sformatf("hold_%0d", j), bus.clb_out, 2'b11);
        end
        bus.prog_en = 1'b0;
        tick();
        chk("swap_out",  bus.clb_out,  2'b00);
        chk("swap_done", bus.cfg_done, 1'b1);
        chk("swap_err",  bus.cfg_err,  1'b0);

        // prog_en pulse that no prog_clk edge sees.
        bus.prog_en = 1'b1;
        #2;
        bus.prog_en = 1'b0;
        tick();
        tick();
        chk("glitch_done", bus.cfg_done, 1'b1);
        chk("glitch_err",  bus.cfg_err,  1'b0);

`ifdef CLB_CFG_PARITY_EN
        shift_in(frame(cfg_a, 1'b1), CW);
        tick();
        chk("par_bad_err",  bus.cfg_err,  1'b1);
        chk("par_bad_done", bus.cfg_done, 1'b1);
        chk("par_bad_out",  bus.clb_out,  2'b00);
        shift_in(frame(cfg_a, 1'b0), CW);
        tick();
        chk("par_ok_err",  bus.cfg_err,  1'b0);
        chk("par_ok_done", bus.cfg_done, 1'b1);
        chk("par_ok_out0", bus.clb_out[0], 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/clb_cluster.md
CLB_CLUSTER -- requirements
Module: clb_cluster

Interface
REQ-001 The block SHALL have parameter K, default 4, meaning LUT inputs per logic element (2..6).
REQ-002 The block SHALL have parameter N, default 2, meaning logic elements (BLEs) per cluster (1..8).
REQ-003 The block SHALL have port prog_clk, input, 1, configuration clock; all configuration logic runs on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have port clb_clk, input, 1, user-logic clock for BLE flip-flops.
REQ-006 The block SHALL have port prog_en, input, 1, shift enable for the configuration chain.
REQ-007 The block SHALL have port prog_in, input, 1, serial configuration data in.
REQ-008 The block SHALL have port prog_out, output, 1, serial chain out (daisy-chain to next cluster).
REQ-009 The block SHALL have port clb_in, input, N*K, BLE i uses bits [i*K +: K].
REQ-010 The block SHALL have port clb_out, output, N, bit i is the BLE i output.
REQ-011 The block SHALL have port cfg_done, output, 1, high while a committed configuration is active.
REQ-012 The block SHALL have port cfg_err, output, 1, last load aborted (wrong length or parity).

Function
REQ-013 Per-BLE field width B = 2^K+2; CFG_W = N*B; CHAIN_W = CFG_W (+1 with parity, REQ-031).
REQ-014 BLE i field at base i*B: [base +: 2^K] LUT truth table; base+2^K mux select (1 = registered); base+2^K+1 FF init value.
REQ-015 Shadow shift register, CHAIN_W bits: on prog_clk edge with prog_en=1, shadow <= {prog_in, shadow[CHAIN_W-1:1]}; prog_out = shadow[0].
REQ-016 After exactly CHAIN_W shifts, the first bit shifted in SHALL sit at shadow[0].
REQ-017 FSM states: IDLE, SHIFT, ACTIVE; reset state IDLE.
REQ-018 IDLE or ACTIVE with prog_en=1 -> SHIFT: bit counter := 1, cfg_err := 0, on that same edge.
REQ-019 In SHIFT with prog_en=1: counter increments, saturating at CHAIN_W+1.
REQ-020 In SHIFT with prog_en=0 (commit edge): if counter==CHAIN_W and parity passes, active config <= shadow[CFG_W-1:0], cfg_done <= 1, state <= ACTIVE.
REQ-021 Otherwise, on the commit edge: cfg_err <= 1; the active config and cfg_done keep their prior values; state <= ACTIVE if cfg_done=1, else IDLE.
REQ-022 During reload from ACTIVE, the old configuration SHALL keep driving clb_out, which switches glitch-free exactly at the commit edge.
REQ-023 LUT output i = active LUT table indexed by clb_in[i*K +: K]; purely combinational from clb_in.
REQ-024 clb_out[i] = mux select ? ff_q[i] : lut_out[i].
REQ-025 cfg_done SHALL be synchronised into clb_clk with a 2-flop synchroniser giving run_en.
REQ-026 While run_en=0, ff_q[i] SHALL load the FF init bit on each clb_clk edge; while run_en=1, ff_q[i] <= lut_out[i].
REQ-027 prog_en toggling with zero shifts (IDLE to IDLE) SHALL not alter any state.

Reset
REQ-028 rst low SHALL immediately clear shadow, active config, counter, cfg_done, cfg_err, synchroniser and ff_q, and force state IDLE, in both clock domains.
REQ-029 During and after reset until the first commit, clb_out, prog_out, cfg_done and cfg_err SHALL all be 0.
REQ-030 Reset mid-shift SHALL discard the partial load; no commit occurs.

Configuration
REQ-031 With CLB_CFG_PARITY_EN defined: CHAIN_W = CFG_W+1; shadow[CFG_W] is an even-parity bit over all CHAIN_W bits; an odd total fails the commit.
REQ-032 Without CLB_CFG_PARITY_EN: CHAIN_W = CFG_W, no parity bit, and only the length check applies.

Verification
REQ-033 K=4,N=2, no macro, 36 shifts: BLE0 LUT 16'h8000 sel 0; BLE1 LUT 16'h6996 sel 1 init 0 -> cfg_done=1 after the commit edge; clb_in=8'h1F gives clb_out[0]=1 at once and clb_out[1]=1 one clb_clk edge after run_en rises.
REQ-034 35 shifts then prog_en=0 -> cfg_err=1, cfg_done=0, clb_out=2'b00.
REQ-035 40 shifts -> cfg_err=1 and no commit; prog_out equals prog_in delayed by 36 prog_clk edges.
REQ-036 Reload while ACTIVE with both LUTs 16'h0000 -> old function holds through all 36 shifts; clb_out goes to 0 on the commit edge.
REQ-037 rst low after 20 shifts -> state IDLE, counter 0, cfg_done=0, clb_out=0; a subsequent full 36-bit load commits normally.
REQ-038 CLB_CFG_PARITY_EN defined: 37-bit load with wrong parity bit -> cfg_err=1, no commit; the same load with correct parity -> cfg_done=1.
